// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over
// a req/rvalid handshake with variable latency, holds the instruction while the
// controller executes it, and commits the next PC from branch/jump controls.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // to controller
  output logic [31:0] instruction,
  output logic [5:0]  opcode,
  output logic [5:0]  function_opcode,
  output logic        inst_valid,
  // from controller / datapath
  input  logic        branch,
  input  logic        n_branch,
  input  logic        jmp,
  input  logic        jal,
  input  logic        jrn,
  input  logic        zero,
  input  logic [31:0] read_data_1,
  input  logic        stall,
  // PC state
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic [31:0] link_addr,
  output logic [31:0] instr_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_EXEC  = 2'd3;

  // Word alignment is a precondition on RESET_PC; clearing the low bits keeps
  // the PC aligned even if a caller gets it wrong.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_link;
  logic [31:0] r_count;

  logic        w_in_fetch;
  logic        w_in_wait;
  logic        w_in_exec;
  logic        w_capture;
  logic        w_commit;
  logic [31:0] w_pc_plus_4;
  logic [31:0] w_br_off;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_jr_target;
  logic        w_br_taken;
  logic [31:0] w_next_pc;

  // read_data_1[1:0] is discarded because jr targets are forced word-aligned.
  logic        w_unused_ok;
  assign w_unused_ok = ^read_data_1[1:0];

  assign w_in_fetch = (r_state == S_FETCH);
  assign w_in_wait  = (r_state == S_WAIT);
  assign w_in_exec  = (r_state == S_EXEC);

  // Only the WAIT state accepts read data; a stale response landing in any
  // other state (e.g. left over from before a reset) is dropped.
  assign w_capture  = w_in_wait & imem_rvalid;
  // Controls are only meaningful in the single non-stalled EXEC cycle.
  assign w_commit   = w_in_exec & ~stall;

  // Next-PC candidates; all arithmetic wraps modulo 2^32.
  assign w_pc_plus_4 = r_pc + 32'd4;
  assign w_br_off    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_br_target = w_pc_plus_4 + w_br_off;
  assign w_j_target  = {w_pc_plus_4[31:28], r_instr[25:0], 2'b00};
  assign w_jr_target = {read_data_1[31:2], 2'b00};
  assign w_br_taken  = (branch & zero) | (n_branch & ~zero);

  // Next-PC select: jr beats j/jal beats conditional branch beats fall-through.
  always_comb begin
    w_next_pc = w_pc_plus_4;
    if (jrn)              w_next_pc = w_jr_target;
    else if (jmp | jal)   w_next_pc = w_j_target;
    else if (w_br_taken)  w_next_pc = w_br_target;
  end

  // FSM next state: IDLE -> FETCH -> WAIT (until rvalid) -> EXEC (until !stall).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT:  if (imem_rvalid) w_state_nxt = S_EXEC;
      S_EXEC:  if (!stall)      w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Instruction register: loaded once per fetch, held through EXEC/stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_instr <= 32'h0;
    else if (w_capture) r_instr <= imem_rdata;
  end

  // Program counter: advances only on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_pc <= RESET_PC_ALIGNED;
    else if (w_commit) r_pc <= w_next_pc;
  end

  // Return address for jal, captured on the committing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_link <= 32'h0;
    else if (w_commit & jal) r_link <= w_pc_plus_4;
  end

  // Committed instruction counter (wraps silently).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_count <= 32'h0;
    else if (w_commit) r_count <= r_count + 32'd1;
  end

  assign imem_req        = w_in_fetch;
  assign imem_addr       = r_pc;
  assign instruction     = r_instr;
  assign opcode          = r_instr[31:26];
  assign function_opcode = r_instr[5:0];
  assign inst_valid      = w_in_exec;
  assign pc              = r_pc;
  assign pc_plus_4       = w_pc_plus_4;
  assign link_addr       = r_link;
  assign instr_count     = r_count;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a table of instructions with hand-computed
// next-PC values, driven through the fetch handshake, plus reset and wrap cases.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_rvalid, inst_valid;
  logic [31:0] imem_addr, imem_rdata, instruction;
  logic [5:0]  opcode, function_opcode;
  logic        branch, n_branch, jmp, jal, jrn, zero, stall;
  logic [31:0] read_data_1, pc, pc_plus_4, link_addr, instr_count;

  // second instance, reset PC at the top of the address space
  logic        wr_req, wr_rvalid, wr_iv;
  logic [31:0] wr_addr, wr_rdata, wr_instr, wr_pc, wr_pc4, wr_link, wr_cnt;
  logic [5:0]  wr_op, wr_fn;

  always #5 clk = ~clk;

  ifetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .opcode(opcode), .function_opcode(function_opcode),
    .inst_valid(inst_valid),
    .branch(branch), .n_branch(n_branch), .jmp(jmp), .jal(jal), .jrn(jrn),
    .zero(zero), .read_data_1(read_data_1), .stall(stall),
    .pc(pc), .pc_plus_4(pc_plus_4), .link_addr(link_addr), .instr_count(instr_count)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(wr_req), .imem_addr(wr_addr),
    .imem_rvalid(wr_rvalid), .imem_rdata(wr_rdata),
    .instruction(wr_instr), .opcode(wr_op), .function_opcode(wr_fn),
    .inst_valid(wr_iv),
    .branch(1'b0), .n_branch(1'b0), .jmp(1'b0), .jal(1'b0), .jrn(1'b0),
    .zero(1'b0), .read_data_1(32'h0), .stall(1'b0),
    .pc(wr_pc), .pc_plus_4(wr_pc4), .link_addr(wr_link), .instr_count(wr_cnt)
  );

  typedef struct {
    logic [31:0] word;
    int          lat;
    int          nstall;
    logic        spur;
    logic        br, nbr, j, jl, jr, z;
    logic [31:0] rd1;
    logic [31:0] exp_next;
  } vec_t;

  localparam logic [31:0] ADD = 32'h0128_5020;  // add $t2,$t1,$t0
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  vec_t        vecs[13];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc, exp_link, exp_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clr_ctrl();
    branch = 0; n_branch = 0; jmp = 0; jal = 0; jrn = 0; zero = 0;
    read_data_1 = 32'h0; stall = 0;
  endtask

  // Entered at a negedge in FETCH; leaves at the negedge of the next FETCH.
  task automatic exec_instr(input vec_t v);
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    chk("pc_plus_4", pc_plus_4, exp_pc + 32'd4);
    imem_rvalid = v.spur; imem_rdata = BAD;
    step();
    for (int k = 1; k <= v.lat; k++) begin
      chk("wait_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("wait_req", {31'b0, imem_req}, 32'd0);
      imem_rvalid = (k == v.lat);
      imem_rdata  = (k == v.lat) ? v.word : BAD;
      step();
    end
    imem_rvalid = v.spur; imem_rdata = BAD;
    // stalled cycles: drive junk controls, nothing may move
    for (int s = 0; s < v.nstall; s++) begin
      stall = 1; jrn = 1; jmp = 1; jal = 1; read_data_1 = 32'h0000_1230;
      chk("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_instr", instruction, v.word);
      chk("stall_pc", pc, exp_pc);
      chk("stall_count", instr_count, exp_count);
      step();
    end
    clr_ctrl();
    branch = v.br; n_branch = v.nbr; jmp = v.j; jal = v.jl; jrn = v.jr;
    zero = v.z; read_data_1 = v.rd1;
    chk("exec_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("exec_instr", instruction, v.word);
    chk("exec_opcode", {26'b0, opcode}, {26'b0, v.word[31:26]});
    chk("exec_funct", {26'b0, function_opcode}, {26'b0, v.word[5:0]});
    chk("exec_pc", pc, exp_pc);
    step();
    if (v.jl) exp_link = exp_pc + 32'd4;
    exp_count = exp_count + 32'd1;
    exp_pc    = v.exp_next;
    clr_ctrl();
    chk("next_addr", imem_addr, exp_pc);
    chk("instr_count", instr_count, exp_count);
    chk("link_addr", link_addr, exp_link);
    chk("post_inst_valid", {31'b0, inst_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //           word          lat st sp br nb j  jl jr z  rd1            next
    vecs[0]  = '{ADD,          1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0004};
    vecs[1]  = '{ADD,          1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0008};
    vecs[2]  = '{32'h0800_0004,1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0,         32'h0000_0010};
    vecs[3]  = '{32'h1000_FFFF,1, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0,         32'h0000_0010};
    vecs[4]  = '{32'h1000_FFFF,2, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0014};
    vecs[5]  = '{32'h1400_FFFF,1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0000_0014};
    vecs[6]  = '{32'h1400_FFFF,1, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0,         32'h0000_0018};
    vecs[7]  = '{32'h0800_0010,1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0,         32'h0000_0040};
    vecs[8]  = '{32'h0C00_0100,1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0,         32'h0000_0400};
    vecs[9]  = '{32'h03E0_0008,1, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0000_0047, 32'h0000_0044};
    vecs[10] = '{ADD,          5, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0048};
    vecs[11] = '{ADD,          1, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_004C};
    vecs[12] = '{32'h1000_0003,1, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0,         32'h0000_005C};

    clr_ctrl();
    imem_rvalid = 0; imem_rdata = 32'h0; wr_rvalid = 0; wr_rdata = 32'h0;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    // reset values, still in IDLE
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus_4", pc_plus_4, 32'h4);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_link", link_addr, 32'h0);
    chk("rst_count", instr_count, 32'h0);
    chk("wrap_rst_pc", wr_pc, 32'hFFFF_FFFC);
    chk("wrap_rst_pc4", wr_pc4, 32'h0);
    step();

    // wrap case on the second instance (first instance parks in WAIT)
    chk("wrap_req", {31'b0, wr_req}, 32'd1);
    chk("wrap_addr", wr_addr, 32'hFFFF_FFFC);
    step();
    wr_rvalid = 1; wr_rdata = ADD;
    step();
    wr_rvalid = 0;
    chk("wrap_exec", {31'b0, wr_iv}, 32'd1);
    step();
    chk("wrap_next_addr", wr_addr, 32'h0);
    chk("wrap_count", wr_cnt, 32'h1);

    // fresh reset for the table
    rst_n = 0;
    step();
    rst_n = 1;
    step();
    exp_pc = 32'h0; exp_link = 32'h0; exp_count = 32'h0;
    foreach (vecs[i]) exec_instr(vecs[i]);

    // reset asserted mid-WAIT: outputs clear at once, stale rvalid ignored
    step();
    step();
    #2 rst_n = 0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_pc_plus_4", pc_plus_4, 32'h4);
    chk("arst_instr", instruction, 32'h0);
    chk("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_link", link_addr, 32'h0);
    chk("arst_count", instr_count, 32'h0);
    imem_rvalid = 1; imem_rdata = BAD;
    @(posedge clk);
    #2 rst_n = 1;
    step();
    chk("post_rst_idle_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("post_rst_instr", instruction, 32'h0);
    imem_rvalid = 0;
    exp_pc = 32'h0; exp_link = 32'h0; exp_count = 32'h0;
    exec_instr('{ADD, 2, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0004});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the single-cycle MIPS datapath, directly upstream of the instruction decoder/controller. Holds the program counter, fetches one 32-bit word per instruction from instruction memory over a request/valid handshake with variable latency, presents the instruction and its opcode and function fields to the controller, and computes the next PC from the controller's branch and jump outputs.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  one-cycle fetch request pulse
- imem_addr  out  32  byte address of the requested word, always equal to pc
- imem_rvalid  in  1  read data valid, response to the outstanding request
- imem_rdata  in  32  instruction word, sampled when imem_rvalid is high in WAIT
- instruction  out  32  registered instruction word
- opcode  out  6  instruction[31:26]
- function_opcode  out  6  instruction[5:0]
- inst_valid  out  1  instruction is executing this cycle (EXEC state)
- branch  in  1  beq, from controller
- n_branch  in  1  bne, from controller
- jmp  in  1  j, from controller
- jal  in  1  jal, from controller
- jrn  in  1  jr, from controller
- zero  in  1  ALU zero flag
- read_data_1  in  32  rs register value, jr target
- stall  in  1  hold the current instruction in EXEC
- pc  out  32  address of the current instruction
- pc_plus_4  out  32  pc + 4, combinational
- link_addr  out  32  return address captured on jal commit
- instr_count  out  32  number of committed instructions

## Operation
- FSM states IDLE, FETCH, WAIT, EXEC. Reset state IDLE.
- IDLE: one cycle, -> FETCH.
- FETCH: imem_req=1, imem_addr=pc; -> WAIT unconditionally.
- WAIT: on imem_rvalid, instruction <= imem_rdata, -> EXEC; otherwise stay. Unbounded wait.
- EXEC: inst_valid=1. If stall=1: stay; pc, instruction, counters unchanged. If stall=0: commit -> pc <= next_pc, instr_count <= instr_count+1, link_addr <= pc_plus_4 when jal=1; -> FETCH.
- next_pc priority: jrn -> {read_data_1[31:2],2'b00}; else jmp or jal -> {pc_plus_4[31:28], instruction[25:0], 2'b00}; else (branch & zero) or (n_branch & ~zero) -> pc_plus_4 + ({{14{instruction[15]}}, instruction[15:0], 2'b00}); else pc_plus_4.
- All PC arithmetic is 32-bit modulo 2^32; wrap at 32'hFFFF_FFFC to 0 with no flag. instr_count wraps likewise.
- Control inputs (branch..jrn, zero, read_data_1) are sampled only in an EXEC cycle with stall=0; ignored elsewhere.
- imem_rvalid outside WAIT is ignored (no capture, no state change).
- Exactly one outstanding request at a time.

## Timing
- Reset values: pc=RESET_PC, instruction=0 (opcode=0, function_opcode=0), inst_valid=0, imem_req=0, link_addr=0, instr_count=0, pc_plus_4=RESET_PC+4.
- Reset is asynchronous: outputs take reset values immediately on rst_n falling, regardless of state; a response to a request issued before reset arrives outside WAIT or before the new FETCH and is ignored. First imem_req is 2 cycles after rst_n deasserts (IDLE, then FETCH).
- Per instruction, stall=0, rvalid latency L>=1 cycles after the FETCH cycle: FETCH 1 + WAIT L + EXEC 1 = L+2 cycles.
- imem_rvalid in the first WAIT cycle (L=1) is captured; instruction visible from the following cycle (EXEC).
- pc updates on the edge ending the committing EXEC cycle; new pc appears on imem_addr in the next FETCH cycle.
- stall held N cycles extends EXEC by N cycles; inst_valid stays high throughout.

## Test plan
- Reset: rst_n low mid-WAIT -> all outputs at reset values at once; stale rvalid ignored; after release imem_req pulses with imem_addr=0 on cycle 2.
- Sequential: memory L=1 returning add words -> imem_addr 0, 4, 8 every 3 cycles; instr_count increments once per EXEC.
- beq taken: pc=0x10, instruction imm=0xFFFF, branch=1, zero=1 -> next imem_addr=0x10; same with zero=0 -> 0x14; bne with zero=0 -> 0x10.
- jal at pc=0x40 target field 0x100 -> next imem_addr=0x400, link_addr=0x44; jr with read_data_1=0x47 and jrn=1 -> 0x44 (jrn wins over simultaneous jmp=1).
- Variable latency and stall: L=5 -> 5 WAIT cycles, spurious rvalid in FETCH/EXEC ignored; stall high 3 cycles in EXEC -> inst_valid high 4 cycles, pc unchanged until release.
- Wrap: RESET_PC=32'hFFFF_FFFC, sequential instruction -> next imem_addr=0.
